// File: rtl/txn_index_allocator_pkg.sv
// Purpose : shared type encoding and default sizing for the transaction index allocator.
// Latency : n/a (declarations only).
// Backpres: n/a.
package types_def;

    // Transaction type encoding shared by mapper, allocator and returner.
    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_type_e;

    localparam int read_entries     = 64;
    localparam int write_entries    = 64;
    localparam int read_entries_log = $clog2(read_entries);
    localparam int stop_margin      = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/txn_index_allocator_lowest_free_finder.sv
// Purpose : priority encoder returning the lowest set bit of a free bitmap.
// Latency : combinational.
// Backpres: none; found=0 when the bitmap is empty (index is then 0).
// Ports   : bitmap (N bits, 1=free) -> found, index (IDX_W bits).
module lowest_free_finder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     bitmap,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        found = |bitmap;
        index = '0;
        // Scan from the top so the last hit written is the lowest one.
        for (int i = N - 1; i >= 0; i--) begin
            if (bitmap[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/txn_index_allocator.sv
// Purpose : read/write global-array index pools; lowest-free allocation, release on completion, stop flags.
// Latency : index presented combinationally with the request; pool state, counts and stop update next edge.
// Backpres: alloc_ready low when the requested type's pool is empty; stop_* flag low-margin registered.
// Ports   : clk/rst_n; alloc_valid/alloc_type -> alloc_ready/alloc_index; rel_valid/rel_type/rel_index;
//           stop_reading/stop_writing, read_outstanding/write_outstanding, err_bad_release (sticky).
module txn_index_allocator
    import types_def::*;
#(
    parameter int READ_ENTRIES  = read_entries,
    parameter int WRITE_ENTRIES = write_entries,
    parameter int STOP_MARGIN   = stop_margin,
    parameter int IDX_W         = $clog2(max_int(READ_ENTRIES, WRITE_ENTRIES))
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               alloc_valid,
    input  logic                               alloc_type,
    output logic                               alloc_ready,
    output logic [IDX_W-1:0]                   alloc_index,
    input  logic                               rel_valid,
    input  logic                               rel_type,
    input  logic [IDX_W-1:0]                   rel_index,
    output logic                               stop_reading,
    output logic                               stop_writing,
    output logic [$clog2(READ_ENTRIES+1)-1:0]  read_outstanding,
    output logic [$clog2(WRITE_ENTRIES+1)-1:0] write_outstanding,
    output logic                               err_bad_release
);

    localparam int RD_CNT_W = $clog2(READ_ENTRIES + 1);
    localparam int WR_CNT_W = $clog2(WRITE_ENTRIES + 1);

    // ---------------------------------------------------------------
    // Read pool
    // ---------------------------------------------------------------
    logic [READ_ENTRIES-1:0] rd_free_q, rd_free_d;
    logic [RD_CNT_W-1:0]     rd_out_q, rd_out_d;
    logic                    rd_stop_q, rd_stop_d;
    logic                    rd_found;
    logic [IDX_W-1:0]        rd_low_idx;
    logic                    rd_alloc, rd_rel, rd_rel_hit;

    lowest_free_finder #(
        .N     (READ_ENTRIES),
        .IDX_W (IDX_W)
    ) u_rd_finder (
        .bitmap (rd_free_q),
        .found  (rd_found),
        .index  (rd_low_idx)
    );

    always_comb begin : rd_pool_comb
        // A release is only honoured for an in-range index that is currently
        // allocated; out-of-range values simply never match a slot.
        rd_rel_hit = 1'b0;
        for (int i = 0; i < READ_ENTRIES; i++) begin
            if (rel_index == IDX_W'(i) && !rd_free_q[i]) begin
                rd_rel_hit = 1'b1;
            end
        end
        rd_alloc = alloc_valid && (alloc_type == TXN_READ) && rd_found;
        rd_rel   = rel_valid && (rel_type == TXN_READ) && rd_rel_hit;

        // Allocation picks from the pre-release bitmap and the released slot
        // is known to be allocated, so the two updates never hit the same bit.
        rd_free_d = rd_free_q;
        for (int i = 0; i < READ_ENTRIES; i++) begin
            if (rd_alloc && rd_low_idx == IDX_W'(i)) rd_free_d[i] = 1'b0;
            if (rd_rel && rel_index == IDX_W'(i))    rd_free_d[i] = 1'b1;
        end
        rd_out_d  = rd_out_q + RD_CNT_W'(rd_alloc) - RD_CNT_W'(rd_rel);
        rd_stop_d = (READ_ENTRIES - int'(rd_out_d)) <= STOP_MARGIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_free_q <= '1;
            rd_out_q  <= '0;
            rd_stop_q <= 1'b0;
        end else begin
            rd_free_q <= rd_free_d;
            rd_out_q  <= rd_out_d;
            rd_stop_q <= rd_stop_d;
        end
    end

    // ---------------------------------------------------------------
    // Write pool
    // ---------------------------------------------------------------
    logic [WRITE_ENTRIES-1:0] wr_free_q, wr_free_d;
    logic [WR_CNT_W-1:0]      wr_out_q, wr_out_d;
    logic                     wr_stop_q, wr_stop_d;
    logic                     wr_found;
    logic [IDX_W-1:0]         wr_low_idx;
    logic                     wr_alloc, wr_rel, wr_rel_hit;

    lowest_free_finder #(
        .N     (WRITE_ENTRIES),
        .IDX_W (IDX_W)
    ) u_wr_finder (
        .bitmap (wr_free_q),
        .found  (wr_found),
        .index  (wr_low_idx)
    );

    always_comb begin : wr_pool_comb
        wr_rel_hit = 1'b0;
        for (int i = 0; i < WRITE_ENTRIES; i++) begin
            if (rel_index == IDX_W'(i) && !wr_free_q[i]) begin
                wr_rel_hit = 1'b1;
            end
        end
        wr_alloc = alloc_valid && (alloc_type == TXN_WRITE) && wr_found;
        wr_rel   = rel_valid && (rel_type == TXN_WRITE) && wr_rel_hit;

        wr_free_d = wr_free_q;
        for (int i = 0; i < WRITE_ENTRIES; i++) begin
            if (wr_alloc && wr_low_idx == IDX_W'(i)) wr_free_d[i] = 1'b0;
            if (wr_rel && rel_index == IDX_W'(i))    wr_free_d[i] = 1'b1;
        end
        wr_out_d  = wr_out_q + WR_CNT_W'(wr_alloc) - WR_CNT_W'(wr_rel);
        wr_stop_d = (WRITE_ENTRIES - int'(wr_out_d)) <= STOP_MARGIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_free_q <= '1;
            wr_out_q  <= '0;
            wr_stop_q <= 1'b0;
        end else begin
            wr_free_q <= wr_free_d;
            wr_out_q  <= wr_out_d;
            wr_stop_q <= wr_stop_d;
        end
    end

    // ---------------------------------------------------------------
    // Shared outputs and sticky release error
    // ---------------------------------------------------------------
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (rel_valid && !(rd_rel || wr_rel));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign alloc_ready       = (alloc_type == TXN_WRITE) ? wr_found   : rd_found;
    assign alloc_index       = (alloc_type == TXN_WRITE) ? wr_low_idx : rd_low_idx;
    assign stop_reading      = rd_stop_q;
    assign stop_writing      = wr_stop_q;
    assign read_outstanding  = rd_out_q;
    assign write_outstanding = wr_out_q;
    assign err_bad_release   = err_q;

endmodule
